pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes,
// data-memory wait freeze with timeout to a sticky error state.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rsa,
  input  logic [4:0]  id_rsb,
  input  logic        id_uses_rsa,
  input  logic        id_uses_rsb,
  input  logic [4:0]  ex_rwa,
  input  logic        ex_is_load,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        idex_flush,
  output logic        exmem_stall,
  output logic        memwb_flush,
  output logic        mem_err,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [7:0] TO = 8'(MEM_TIMEOUT);

  state_t     st, st_nx;
  logic [7:0] cnt, cnt_nx;
  logic       err_q;
  logic [15:0] scnt;

  logic mem_hold, in_err, hit_a, hit_b, load_use;
  logic freeze, br_act, lu_act;

  assign mem_hold = mem_req & ~mem_ack;
  assign in_err   = (st == ERR);
  assign hit_a    = id_uses_rsa & (id_rsa == ex_rwa);
  assign hit_b    = id_uses_rsb & (id_rsb == ex_rwa);
  assign load_use = ex_is_load & (ex_rwa != 5'd0) & (hit_a | hit_b);

  // Mutually exclusive one-hot priority: ERR > mem_hold > branch > load-use
  assign freeze = rst_n & (in_err | mem_hold);
  assign br_act = rst_n & ~in_err & ~mem_hold & ex_branch_taken;
  assign lu_act = rst_n & ~in_err & ~mem_hold & ~ex_branch_taken
                & load_use;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= RUN;
      cnt   <= 8'd0;
      err_q <= 1'b0;
      scnt  <= 16'd0;
    end else begin
      st    <= st_nx;
      cnt   <= cnt_nx;
      err_q <= err_q | (st_nx == ERR);
      if (pc_stall && scnt != 16'hFFFF)
        scnt <= scnt + 16'd1;
    end
  end

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    unique case (st)
      RUN: begin
        if (mem_hold) begin
          st_nx  = MEM_WAIT;
          cnt_nx = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!mem_hold) begin
          st_nx  = RUN;
          cnt_nx = 8'd0;
        end else if (cnt >= TO) begin
          st_nx  = ERR;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      ERR: st_nx = ERR;
      default: begin
        st_nx  = RUN;
        cnt_nx = 8'd0;
      end
    endcase
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;
    unique case (1'b1)
      freeze: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end
      br_act: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      lu_act: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_err   = err_q;
  assign state     = st;
  assign stall_cnt = scnt;

endmodule
